data_mem_io_responder: RTL
==========================

Name: data_mem_io_responder

Overview:
- Responder side of the CPU data-memory interface (address, write data, write enable in; read data out).
- Services word-aligned loads and stores to an on-chip data RAM and a memory-mapped I/O region.
- I/O region contains: synchronized switch/key inputs, key edge flags, LED and 7-segment output registers, a free-running cycle counter, and a down-counting timer.
- Sits beside the pipelined CPU; rdata feeds the CPU's MEM-stage data input.

Parameters:
- ADDR_WIDTH, 8, RAM word-address width (RAM holds 2^ADDR_WIDTH 32-bit words).
- INIT_FILE, "", hex image loaded into RAM at elaboration; empty means no preload.
- SW_WIDTH, 10, number of switch inputs.
- KEY_WIDTH, 4, number of key inputs.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  byte address from CPU (ALU result).
- wdata  input  32  store data from CPU.
- we  input  1  store enable from CPU.
- rdata  output  32  load data to CPU; combinational in addr.
- sw  input  SW_WIDTH  raw switch levels, asynchronous.
- key  input  KEY_WIDTH  raw key levels, asynchronous, 1 = pressed.
- led  output  SW_WIDTH  LED register.
- hex  output  24  six 4-bit digit values for 7-segment decoders.
- timer_irq  output  1  copy of the timer expired flag.

Behaviour:
- Clock/reset: one clock, clock; reset is asynchronous and active-high.
- Reset values:
  - led = 0, hex = 0, timer_irq = 0.
  - Cycle counter, timer load, timer count, timer control, key edge flags and all synchronizer flops = 0.
  - RAM contents are not reset.
- Decode:
  - addr[31] = 0: RAM. Word index = addr[ADDR_WIDTH+1:2]; upper bits ignored, so the RAM aliases/wraps. addr[1:0] ignored.
  - addr[31] = 1: I/O. Offset = addr[7:2]; other bits ignored.
- Reads: rdata is combinational from addr and current register/RAM state, zero latency. Narrow fields are zero-extended. Unmapped I/O offsets read 0.
- Writes: take effect at the rising edge when we = 1. Read-after-write to the same address returns the new value from the next cycle. Writes to read-only or unmapped offsets are ignored.
- I/O map (byte offsets from 0x8000_0000):
  - 0x00 SW, RO: sw after a 2-flop synchronizer. A change is visible after 2 edges.
  - 0x04 KEY, RO: key after a 2-flop synchronizer.
  - 0x08 KEY_EDGE, R/W1C: sticky flag per key.
    - Set when synchronized key is 1 and its previous sample is 0.
    - Writing 1 to a bit clears it.
    - A new edge in the same cycle as a clear: set wins.
  - 0x10 LED, RW: low SW_WIDTH bits.
  - 0x14 HEX, RW: low 24 bits.
  - 0x20 CYCLE, RO: increments every cycle, wraps 0xFFFF_FFFF -> 0.
  - 0x24 TIMER_LOAD, RW: a write also sets TIMER_COUNT = wdata that edge; no decrement that edge.
  - 0x28 TIMER_CTRL: bit0 enable (RW), bit1 auto_reload (RW), bit8 expired (R/W1C); other bits read 0.
  - 0x2C TIMER_COUNT, RO.
- Timer, each edge with enable = 1 and no TIMER_LOAD write:
  - count > 1: count decrements.
  - count = 1: expired is set. Count becomes TIMER_LOAD if auto_reload, else 0.
  - count = 0: holds; no new expiry.
  - enable = 0: count holds.
- Expiry and a W1C of expired in the same cycle: expiry wins, flag stays 1.
- A TIMER_CTRL write updates enable/auto_reload at that edge; the new enable governs the following edges.
- timer_irq = expired flag, registered, no extra latency.
- Reset asserted mid-operation clears all registers immediately (asynchronously). RAM keeps its contents; a store in flight at that edge is dropped.

Test Plan:
- Store 0x1234_5678 to 0x0000_0010, then load 0x0000_0010 and 0x0000_0010 + (4<<ADDR_WIDTH) -> both return 0x1234_5678 (alias); load of 0x0000_0014 is unaffected.
- Set sw = 0x2A5 -> read 0x8000_0000 returns 0 before 2 edges and 0x0000_02A5 from the 3rd cycle on; write 0x3FF to 0x8000_0010 -> led = 0x3FF next cycle; read 0x8000_0030 -> 0.
- Pulse key[2] high for 5 cycles -> KEY_EDGE = 0x4. Write 0x4 to 0x8000_0008 while key[0] rises in the same cycle -> next read 0x1 (set wins; bit2 cleared).
- Write TIMER_LOAD = 3, TIMER_CTRL = 0x3 -> count 3, 2, 1, then reload to 3 with expired = 1 and timer_irq = 1. Write 0x100 to TIMER_CTRL on a cycle where count = 1 -> expired remains 1.
- Timer with auto_reload = 0, load 2 -> count reaches 0 and holds. Expired is set exactly once. Writing 0x100 clears it and timer_irq drops next cycle.
- Assert reset mid-countdown with led = 0x155 and CYCLE = 50 -> led, hex, CYCLE, TIMER_COUNT, flags read 0 immediately. RAM word written before reset still reads back.

Source files
------------

// File: rtl/data_mem_io_responder.sv
// data_mem_io_responder
//   Responder side of the CPU data-memory interface. Word-aligned loads and
//   stores go to an on-chip data RAM (addr[31] = 0) or to a memory-mapped I/O
//   block (addr[31] = 1). The I/O block holds synchronized switches and keys,
//   sticky key edge flags, LED and 7-segment registers, a free-running cycle
//   counter and a down-counting timer.
//
// Ports
//   clock, reset      : system clock (rising edge), async active-high reset
//   addr, wdata, we   : CPU byte address, store data, store enable
//   rdata             : load data, combinational in addr and current state
//   sw, key           : raw asynchronous switch / key levels (key 1 = pressed)
//   led, hex          : LED register, six 4-bit 7-segment digit values
//   timer_irq         : registered timer expired flag
//
// Bus handshake: there is none. Every cycle is a transfer; a load returns
// data in the same cycle and a store with we = 1 commits at the rising edge.
module data_mem_io_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter     INIT_FILE  = "",
  parameter int SW_WIDTH   = 10,
  parameter int KEY_WIDTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic                 we,
  output logic [31:0]          rdata,
  input  logic [SW_WIDTH-1:0]  sw,
  input  logic [KEY_WIDTH-1:0] key,
  output logic [SW_WIDTH-1:0]  led,
  output logic [23:0]          hex,
  output logic                 timer_irq
);

  // I/O word offsets (byte offset >> 2)
  localparam logic [5:0] OFF_SW     = 6'h00;
  localparam logic [5:0] OFF_KEY    = 6'h01;
  localparam logic [5:0] OFF_KEDGE  = 6'h02;
  localparam logic [5:0] OFF_LED    = 6'h04;
  localparam logic [5:0] OFF_HEX    = 6'h05;
  localparam logic [5:0] OFF_CYCLE  = 6'h08;
  localparam logic [5:0] OFF_TLOAD  = 6'h09;
  localparam logic [5:0] OFF_TCTRL  = 6'h0A;
  localparam logic [5:0] OFF_TCOUNT = 6'h0B;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic                  is_io;
  logic [5:0]            io_off;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  wr_kedge, wr_led, wr_hex, wr_tload, wr_tctrl;

  logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
  logic [KEY_WIDTH-1:0] key_s1, key_s2, key_prev, key_edge;
  logic [31:0]          cycle_count;
  logic [31:0]          timer_load, timer_count;
  logic                 timer_en, timer_auto, timer_expired;
  logic                 expire;

  wire unused_addr_bits = &{1'b0, addr[1:0], addr[30:ADDR_WIDTH+2]};

  assign is_io   = addr[31];
  assign io_off  = addr[7:2];
  assign ram_idx = addr[ADDR_WIDTH+1:2];

  assign wr_kedge = we && is_io && (io_off == OFF_KEDGE);
  assign wr_led   = we && is_io && (io_off == OFF_LED);
  assign wr_hex   = we && is_io && (io_off == OFF_HEX);
  assign wr_tload = we && is_io && (io_off == OFF_TLOAD);
  assign wr_tctrl = we && is_io && (io_off == OFF_TCTRL);

  // A TIMER_LOAD write takes priority over counting at the same edge.
  assign expire = timer_en && !wr_tload && (timer_count == 32'd1);

  // RAM is not reset; a store coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (we && !is_io && !reset) mem[ram_idx] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_s1       <= '0;
      sw_s2       <= '0;
      key_s1      <= '0;
      key_s2      <= '0;
      key_prev    <= '0;
      key_edge    <= '0;
      led         <= '0;
      hex         <= '0;
      cycle_count <= '0;
    end else begin
      sw_s1       <= sw;
      sw_s2       <= sw_s1;
      key_s1      <= key;
      key_s2      <= key_s1;
      key_prev    <= key_s2;
      cycle_count <= cycle_count + 32'd1;
      // Clear first, then OR in new edges so a coincident edge wins.
      key_edge    <= (key_edge & ~(wr_kedge ? wdata[KEY_WIDTH-1:0] : '0))
                   | (key_s2 & ~key_prev);
      if (wr_led) led <= wdata[SW_WIDTH-1:0];
      if (wr_hex) hex <= wdata[23:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_load    <= '0;
      timer_count   <= '0;
      timer_en      <= 1'b0;
      timer_auto    <= 1'b0;
      timer_expired <= 1'b0;
    end else begin
      if (wr_tload) begin
        timer_load  <= wdata;
        timer_count <= wdata;
      end else if (timer_en) begin
        if (timer_count > 32'd1)       timer_count <= timer_count - 32'd1;
        else if (timer_count == 32'd1) timer_count <= timer_auto ? timer_load : 32'd0;
      end
      if (wr_tctrl) begin
        timer_en   <= wdata[0];
        timer_auto <= wdata[1];
      end
      if (expire)                    timer_expired <= 1'b1;
      else if (wr_tctrl && wdata[8]) timer_expired <= 1'b0;
    end
  end

  assign timer_irq = timer_expired;

  always_comb begin
    rdata = 32'd0;
    if (!is_io) begin
      rdata = mem[ram_idx];
    end else begin
      case (io_off)
        OFF_SW:     rdata = {{(32-SW_WIDTH){1'b0}}, sw_s2};
        OFF_KEY:    rdata = {{(32-KEY_WIDTH){1'b0}}, key_s2};
        OFF_KEDGE:  rdata = {{(32-KEY_WIDTH){1'b0}}, key_edge};
        OFF_LED:    rdata = {{(32-SW_WIDTH){1'b0}}, led};
        OFF_HEX:    rdata = {8'd0, hex};
        OFF_CYCLE:  rdata = cycle_count;
        OFF_TLOAD:  rdata = timer_load;
        OFF_TCTRL:  rdata = {23'd0, timer_expired, 6'd0, timer_auto, timer_en};
        OFF_TCOUNT: rdata = timer_count;
        default:    rdata = 32'd0;
      endcase
    end
  end

endmodule
